alu_op_sequencer: RTL and testbench

//  Hardware control sequencer for register-register ALU instructions; replaces hand-driven T0..T6 strobes.

---
 rtl/alu_op_sequencer_pkg.sv | 39 +++
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_op_sequencer_reg_sel_decoder.sv | 16 +
 rtl/alu_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU op sequencer: state enum, opcode map, IR field layout.
// The optional single-step feature is selected elsewhere with SEQ_STEP_EN.
package alu_seq_pkg;

  localparam int OPCODE_W = 5;
  localparam int FIELD_W  = 4;

  localparam int OP_MSB = 31;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [OPCODE_W-1:0] OP_SUB      = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_MUL      = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV      = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_RFMT_MAX = 5'b01110;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ERR
  } seq_state_e;

  typedef enum logic [1:0] {
    K_RFMT, K_MULDIV, K_ILLEGAL
  } op_kind_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] op;
    logic [FIELD_W-1:0]  ra;
    logic [FIELD_W-1:0]  rb;
    logic [FIELD_W-1:0]  rc;
  } ir_fields_t;

  function automatic op_kind_e classify(input logic [OPCODE_W-1:0] op);
    if (op <= OP_RFMT_MAX)                return K_RFMT;
    else if (op == OP_MUL || op == OP_DIV) return K_MULDIV;
    else                                   return K_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the sequencer (slave) and the controller/Datapath side (master).
// The step input exists only when SEQ_STEP_EN is defined.
interface alu_op_sequencer_if #(
  parameter int NUM_REGS = 16
);
  import alu_seq_pkg::*;

  // start is a request accepted only while busy is low (IDLE); mem_ready is the
  // valid qualifier for memory data and is consumed only while the fetch waits in T1.
  logic                start;
  logic                mem_ready;
  logic [31:0]         ir;
`ifdef SEQ_STEP_EN
  logic                step;
`endif
  logic                PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic                Zlowout, Zhighout, HIin, LOin;
  logic [NUM_REGS-1:0] Rout;
  logic [NUM_REGS-1:0] Rin;
  logic [OPCODE_W-1:0] opcode;
  logic                busy, done, err;

  modport master (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output start, mem_ready, ir,
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Zlowout, Zhighout, HIin, LOin, Rout, Rin, opcode, busy, done, err
  );

  modport slave (
`ifdef SEQ_STEP_EN
    input  step,
`endif
    input  start, mem_ready, ir,
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Zlowout, Zhighout, HIin, LOin, Rout, Rin, opcode, busy, done, err
  );

endinterface

// File: rtl/alu_op_sequencer_reg_sel_decoder.sv
// Binary register index plus enable to a one-hot (or all-zero) register strobe vector.
module reg_sel_decoder #(
  parameter int NUM_REGS = 16,
  parameter int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic [RSEL_W-1:0]   idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for register-register ALU instructions: fetch, operand, writeback T states.
// Define SEQ_STEP_EN to hold every T state until a step pulse.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  alu_op_sequencer_if.slave bus,
  output seq_state_e        state_dbg
);

  localparam int RSEL_W = $clog2(NUM_REGS);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_e  state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  ir_fields_t  ir_q, ir_d;
  ir_fields_t  live;
  op_kind_e    live_kind, held_kind;
  logic        adv;

  logic              rout_en, rin_en;
  logic [RSEL_W-1:0] rout_idx, rin_idx;
  logic              unused_ir_bits;

`ifdef SEQ_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  assign live.op        = bus.ir[OP_MSB -: OPCODE_W];
  assign live.ra        = bus.ir[RA_LSB +: FIELD_W];
  assign live.rb        = bus.ir[RB_LSB +: FIELD_W];
  assign live.rc        = bus.ir[RC_LSB +: FIELD_W];
  assign unused_ir_bits = ^bus.ir[RC_LSB-1:0];
  assign live_kind      = classify(live.op);
  assign held_kind      = classify(ir_q.op);
  assign state_dbg      = state_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    case (state_q)
      IDLE: if (bus.start) state_d = T0;
      T0: begin
        wait_cnt_d = '0;
        if (adv) state_d = T1;
      end
      // The timeout counts every stalled cycle, whether or not a step pulse arrives.
      T1: begin
        if (!bus.mem_ready) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) state_d = ERR;
        end else if (adv) begin
          state_d = T2;
        end
      end
      T2: if (adv) state_d = T3;
      T3: begin
        if (adv) begin
          if (live_kind == K_ILLEGAL) begin
            state_d = ERR;
          end else begin
            state_d = T4;
            ir_d    = live;
          end
        end
      end
      T4: if (adv) state_d = T5;
      T5: if (adv) state_d = (held_kind == K_MULDIV) ? T6 : DONE;
      T6: if (adv) state_d = DONE;
      DONE, ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.opcode   = '0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    rout_en      = 1'b0;
    rout_idx     = '0;
    rin_en       = 1'b0;
    rin_idx      = '0;
    case (state_q)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      // Decoded straight from the Datapath IR; an illegal opcode drives nothing.
      T3: begin
        if (live_kind != K_ILLEGAL) begin
          bus.Yin  = 1'b1;
          rout_en  = 1'b1;
          rout_idx = (live_kind == K_RFMT) ? live.rb[RSEL_W-1:0] : live.ra[RSEL_W-1:0];
        end
      end
      T4: begin
        rout_en    = 1'b1;
        rout_idx   = (held_kind == K_RFMT) ? ir_q.rc[RSEL_W-1:0] : ir_q.rb[RSEL_W-1:0];
        bus.opcode = ir_q.op;
        bus.Zin    = 1'b1;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (held_kind == K_RFMT) begin
          rin_en  = 1'b1;
          rin_idx = ir_q.ra[RSEL_W-1:0];
        end else begin
          bus.LOin = 1'b1;
        end
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      DONE: bus.done = 1'b1;
      ERR:  bus.err  = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed cases plus random instructions, checked cycle by cycle
// against a per-instruction strobe schedule derived from the instruction timing rules.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int NUM_REGS    = 16;
  localparam int MEM_TIMEOUT = 15;
`ifdef SEQ_STEP_EN
  localparam int PER_MAX = 4;
`else
  localparam int PER_MAX = 1;
`endif

  typedef struct packed {
    logic busy, done, err;
    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, Zhighout, HIin, LOin;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic [4:0] opcode;
  } snap_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       clear;
  seq_state_e state_dbg;

  alu_op_sequencer_if #(.NUM_REGS(NUM_REGS)) bus ();

  alu_op_sequencer #(.NUM_REGS(NUM_REGS), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock     (clock),
    .clear     (clear),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  snap_t exp_q[$];
  logic  mr_q[$];
  logic  step_q[$];
  logic  irr_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic snap_t observe();
    snap_t s;
    s.busy = bus.busy;       s.done = bus.done;         s.err = bus.err;
    s.PCout = bus.PCout;     s.MARin = bus.MARin;       s.IncPC = bus.IncPC;
    s.Zin = bus.Zin;         s.PCin = bus.PCin;         s.Read = bus.Read;
    s.MDRin = bus.MDRin;     s.MDRout = bus.MDRout;     s.IRin = bus.IRin;
    s.Yin = bus.Yin;         s.Zlowout = bus.Zlowout;   s.Zhighout = bus.Zhighout;
    s.HIin = bus.HIin;       s.LOin = bus.LOin;
    s.Rout = bus.Rout;       s.Rin = bus.Rin;           s.opcode = bus.opcode;
    return s;
  endfunction

  task automatic check(input string tag, input int cyc, input snap_t got, input snap_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One schedule phase: dur cycles of the same expected outputs.
  // mr_mode 0/1 fixes mem_ready, 2 randomises it; T states pulse step on their last cycle.
  task automatic add(input snap_t e, input int dur, input int mr_mode, input bit irr, input bit tstate);
    for (int i = 0; i < dur; i++) begin
      exp_q.push_back(e);
      mr_q.push_back(mr_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(mr_mode));
      irr_q.push_back(irr);
      step_q.push_back(tstate ? (i == dur - 1) : 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- reference model ----------------
  task automatic gen(input logic [31:0] instr, input int stall, input int per);
    int    op, ra, rb, rc;
    bit    muldiv;
    snap_t e;
    exp_q.delete(); mr_q.delete(); step_q.delete(); irr_q.delete();
    op = int'(instr >> 27);
    ra = int'((instr >> 23) & 32'd15);
    rb = int'((instr >> 19) & 32'd15);
    rc = int'((instr >> 15) & 32'd15);
    muldiv = (op == 15) || (op == 16);

    e = '0; e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
    add(e, per, 2, 0, 1);
    e = '0; e.busy = 1; e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
    if (stall >= MEM_TIMEOUT) begin
      add(e, MEM_TIMEOUT, 0, 0, 0);
      e = '0; e.busy = 1; e.err = 1;
      add(e, 1, 2, 0, 0);
      return;
    end
    add(e, stall, 0, 0, 0);
    add(e, per, 1, 0, 1);
    e = '0; e.busy = 1; e.MDRout = 1; e.IRin = 1;
    add(e, per, 2, 0, 1);
    if (op > 16) begin
      e = '0; e.busy = 1;
      add(e, per, 2, 1, 1);
      e = '0; e.busy = 1; e.err = 1;
      add(e, 1, 2, 0, 0);
      return;
    end
    e = '0; e.busy = 1; e.Yin = 1; e.Rout[muldiv ? ra : rb] = 1'b1;
    add(e, per, 2, 1, 1);
    e = '0; e.busy = 1; e.Zin = 1; e.opcode = 5'(op); e.Rout[muldiv ? rb : rc] = 1'b1;
    add(e, per, 2, 0, 1);
    e = '0; e.busy = 1; e.Zlowout = 1;
    if (muldiv) e.LOin = 1; else e.Rin[ra] = 1'b1;
    add(e, per, 2, 0, 1);
    if (muldiv) begin
      e = '0; e.busy = 1; e.Zhighout = 1; e.HIin = 1;
      add(e, per, 2, 0, 1);
    end
    e = '0; e.busy = 1; e.done = 1;
    add(e, 1, 2, 0, 0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic mr, input logic stp, input bit ir_real, input logic [31:0] instr);
    bus.mem_ready = mr;
    bus.ir        = ir_real ? instr : $urandom;
`ifdef SEQ_STEP_EN
    bus.step      = stp;
`else
    if (stp) ;
`endif
  endtask

  // Entered and left just after a falling edge with the DUT idle.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int stall,
                           input int per, input int abort_at);
    int len;
    gen(instr, stall, per);
    len = exp_q.size();
    check({tag, "_idle"}, 0, observe(), '0);
    bus.start = 1'b1;
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), irr_q[0], instr);
    for (int n = 1; n <= len; n++) begin
      @(negedge clock);
      check(tag, n, observe(), exp_q[n-1]);
      if (n == abort_at) begin
        clear = 1'b1;
        #1;
        check({tag, "_clear_async"}, n, observe(), '0);
        @(negedge clock);
        check({tag, "_clear_hold"}, n + 1, observe(), '0);
        bus.start = 1'b0;
        clear = 1'b0;
        return;
      end
      bus.start = 1'($urandom_range(0, 1));
      if (n < len) drive(mr_q[n-1], step_q[n-1], irr_q[n-1] || irr_q[n], instr);
      else         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, instr);
    end
    bus.start = 1'b0;
    @(negedge clock);
  endtask

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = 5'(op); w[26:23] = 4'(ra); w[22:19] = 4'(rb); w[18:15] = 4'(rc);
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clear = 1'b1;
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = '0;
`ifdef SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    #1;
    check("reset", 0, observe(), '0);
    @(negedge clock);
    @(negedge clock);
    check("reset_hold", 0, observe(), '0);
    clear = 1'b0;

    run_instr("sub_r1_r2_r3", 32'h18918000, 0, 1, 0);
    run_instr("mul_r2_r3",    32'h79180000, 0, 1, 0);
    run_instr("div",          mk(16, 5, 9, 0), 0, 1, 0);
    run_instr("sub_stall3",   32'h18918000, 3, 1, 0);
    run_instr("stall14",      mk(7, 4, 6, 8), 14, 1, 0);
    run_instr("timeout16",    32'h18918000, 16, 1, 0);
    run_instr("illegal_f8",   32'hF8000000, 0, 1, 0);
    run_instr("illegal_17",   mk(17, 1, 2, 3), 0, 1, 0);
    run_instr("abort_t4",     32'h18918000, 0, 1, 5);
    run_instr("after_abort",  mk(14, 15, 0, 7), 0, 1, 0);
`ifdef SEQ_STEP_EN
    run_instr("step5_sub",    32'h18918000, 0, 5, 0);
    run_instr("step3_mul",    32'h79180000, 2, 3, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int kind, op, stall;
      kind = $urandom_range(0, 9);
      if (kind <= 5)      op = $urandom_range(0, 14);
      else if (kind <= 7) op = $urandom_range(15, 16);
      else if (kind == 8) op = $urandom_range(17, 31);
      else                op = 3;
      stall = (kind == 9) ? $urandom_range(13, 17) : $urandom_range(0, 4);
      run_instr("random", mk(op, $urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 15)), stall, $urandom_range(1, PER_MAX), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
